dcollide_batch_ctrl: RTL
========================

Name: dcollide_batch_ctrl

Overview:
Parametrised sequencer for the DCOLLIDE datapath.
- LOAD phase: streams input words into the input memory.
- RUN phase: repeatedly starts the collision core, waits for its done handshake, captures NUM_CH result words and writes them serially to the output memory.
- Sits between the host-side memory loader and the collision core. Adds over the previous control unit: configurable channels and depths, batch count, serial result write, core timeout and output-overflow error reporting.

Parameters:
DATA_W, 32, width of each result/data word
NUM_CH, 8, result words produced per core run
IN_DEPTH, 256, input memory depth (words)
OUT_DEPTH, 256, output memory depth (words)
BATCH_W, 8, width of batch count
TIMEOUT_CYC, 1024, max cycles waiting on core_done before error

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-high
load_en  in  1  request LOAD phase (sampled in IDLE)
in_valid  in  1  input word present on loader side
in_ready  out  1  controller accepts input word
in_we  out  1  input memory write enable
in_addr  out  clog2(IN_DEPTH)  input memory write address
start  in  1  request RUN phase (sampled in IDLE)
num_batches  in  BATCH_W  core runs to perform; latched on start
core_start  out  1  one-cycle core start pulse
core_done  in  1  core done level (high when idle/finished)
core_res  in  NUM_CH*DATA_W  packed core results, channel 0 in LSBs
core_oe  out  1  core output enable, high during RUN
out_we  out  1  output memory write enable
out_addr  out  clog2(OUT_DEPTH)  output memory write address
out_data  out  DATA_W  output memory write data
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when RUN completes normally
err_timeout  out  1  sticky; core_done handshake timed out
err_ovf  out  1  sticky; output memory would overflow
batch_cnt  out  BATCH_W  completed batches in current RUN

Behaviour:
- Reset: state IDLE; all outputs 0; addresses 0; capture register 0. Reset mid-operation aborts immediately, with no completing write.
- States: IDLE, LOAD, START, WAIT_ACK, WAIT_DONE, CAPTURE, WRITE, FINISH.
- IDLE transitions:
  - start=1 -> START, with priority over load_en. Latches num_batches, clears batch_cnt, out_addr and errors.
  - start=1 with num_batches=0 -> FINISH directly.
  - load_en=1 -> LOAD; in_addr cleared to 0.
- LOAD:
  - in_ready=1 while in_addr < IN_DEPTH.
  - Each cycle with in_valid&in_ready: in_we=1 for that cycle at the current in_addr, then in_addr increments.
  - Once the last address (IN_DEPTH-1) is written, in_ready=0 and further in_valid is ignored. No wrap.
  - load_en=0 -> IDLE.
- START: core_start=1 for exactly one cycle; timeout counter cleared -> WAIT_ACK.
- WAIT_ACK: wait for core_done=0 (core acknowledged) -> WAIT_DONE.
- WAIT_DONE: wait for core_done=1 -> CAPTURE.
- Timeout: counter runs across WAIT_ACK+WAIT_DONE. Reaching TIMEOUT_CYC sets err_timeout and goes to FINISH, with no done pulse.
- CAPTURE: register all of core_res in one cycle.
  - If out_addr + NUM_CH > OUT_DEPTH: set err_ovf, go to FINISH, no write.
  - Otherwise -> WRITE.
- WRITE: NUM_CH consecutive cycles.
  - Cycle k: out_we=1, out_data=channel k, out_addr increments after each write.
  - After the last write, batch_cnt increments. If batch_cnt equals the latched count -> FINISH, else -> START.
- FINISH: done=1 for one cycle only if no error -> IDLE.
- Write latency: the first out_we occurs 1 cycle after the core_done rising edge is sampled.
- core_oe=1 in START through WRITE.
- Errors are sticky until the next accepted start or reset.

Decomposition:
- Shared package dcollide_pkg:
  - state encoding enum
  - clog2-derived address widths
- One sub-module, dcollide_res_serializer: captures the NUM_CH*DATA_W result bus and shifts out one word per cycle with a last flag.

Test Plan:
- LOAD: load_en=1, 256 words with in_valid held high -> in_we asserted 256 cycles, in_addr 0..255. in_ready=0 afterward; word 257 is not written.
- RUN, num_batches=3, core model drops done 2 cycles after core_start and raises it 5 cycles later -> 24 out_we pulses, out_addr 0..23, data matches channel order. done pulses once; batch_cnt=3.
- Timeout: core never raises core_done, TIMEOUT_CYC=16 -> err_timeout=1 on cycle 16 of waiting, no out_we, no done, back to IDLE.
- Overflow: OUT_DEPTH=16, NUM_CH=8, num_batches=3 -> two batches written (addresses 0..15), err_ovf=1 at the third CAPTURE, no done.
- start and load_en both high in IDLE -> RUN entered; in_we never asserted.
- rst asserted during WRITE, mid-batch -> all outputs 0 asynchronously. After release, state is IDLE and the next RUN starts at out_addr 0.

Source files
------------

// File: rtl/dcollide_pkg.sv
// Shared types and helpers for the DCOLLIDE batch controller.
// Holds the sequencer state encoding and the address-width rule used for memory ports.
package dcollide_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWaitAck,
    StWaitDone,
    StCapture,
    StWrite,
    StFinish
  } state_e;

  // Memory address width; a one-word memory still gets a 1-bit address.
  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dcollide_res_serializer.sv
// Captures the packed core result bus and presents one word per cycle, channel 0 first.
// valid stays high for exactly NUM_CH cycles after load; last marks the final word.
module dcollide_res_serializer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_CH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [NUM_CH*DATA_W-1:0] res,
  output logic                     valid,
  output logic                     last,
  output logic [DATA_W-1:0]        data
);

  localparam int unsigned CntW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(NUM_CH - 1);

  logic [NUM_CH*DATA_W-1:0] shreg;
  logic [CntW-1:0]          idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      idx   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      shreg <= res;
      idx   <= '0;
      valid <= 1'b1;
    end else if (valid) begin
      shreg <= shreg >> DATA_W;
      idx   <= idx + CntW'(1);
      if (idx == LastIdx) valid <= 1'b0;
    end
  end

  assign data = shreg[DATA_W-1:0];
  assign last = valid && (idx == LastIdx);

endmodule

// File: rtl/dcollide_batch_ctrl.sv
// Batch sequencer for the DCOLLIDE datapath: loads the input memory, then runs the core
// num_batches times, writing NUM_CH result words per run serially to the output memory.
module dcollide_batch_ctrl
  import dcollide_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned IN_DEPTH    = 256,
  parameter int unsigned OUT_DEPTH   = 256,
  parameter int unsigned BATCH_W     = 8,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_en,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         in_we,
  output logic [addr_w(IN_DEPTH)-1:0]  in_addr,
  input  logic                         start,
  input  logic [BATCH_W-1:0]           num_batches,
  output logic                         core_start,
  input  logic                         core_done,
  input  logic [NUM_CH*DATA_W-1:0]     core_res,
  output logic                         core_oe,
  output logic                         out_we,
  output logic [addr_w(OUT_DEPTH)-1:0] out_addr,
  output logic [DATA_W-1:0]            out_data,
  output logic                         busy,
  output logic                         done,
  output logic                         err_timeout,
  output logic                         err_ovf,
  output logic [BATCH_W-1:0]           batch_cnt
);

  localparam int unsigned InAw    = addr_w(IN_DEPTH);
  localparam int unsigned OutAw   = addr_w(OUT_DEPTH);
  // One spare range so out_cnt + NUM_CH never wraps in the overflow check.
  localparam int unsigned OutCntW = $clog2(OUT_DEPTH + NUM_CH + 1);
  localparam int unsigned ToW     = $clog2(TIMEOUT_CYC + 1);

  state_e               state;
  logic [OutCntW-1:0]   out_cnt;
  logic [ToW-1:0]       to_cnt;
  logic [BATCH_W-1:0]   nb;
  logic                 ovf_now;
  logic                 to_expired;
  logic                 ser_load;
  logic                 ser_last;

  assign in_we      = in_valid & in_ready;
  assign out_addr   = out_cnt[OutAw-1:0];
  assign ovf_now    = (out_cnt + OutCntW'(NUM_CH)) > OutCntW'(OUT_DEPTH);
  assign to_expired = (to_cnt == ToW'(TIMEOUT_CYC - 1));
  assign ser_load   = (state == StCapture) && !ovf_now;

  dcollide_res_serializer #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH)
  ) u_ser (
    .clk   (clk),
    .rst   (rst),
    .load  (ser_load),
    .res   (core_res),
    .valid (out_we),
    .last  (ser_last),
    .data  (out_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      in_ready    <= 1'b0;
      in_addr     <= '0;
      core_start  <= 1'b0;
      core_oe     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      err_ovf     <= 1'b0;
      batch_cnt   <= '0;
      nb          <= '0;
      out_cnt     <= '0;
      to_cnt      <= '0;
    end else begin
      core_start <= 1'b0;
      done       <= 1'b0;
      // Input address saturates at the last word; in_ready drops instead of wrapping.
      if (in_we) begin
        if (in_addr == InAw'(IN_DEPTH - 1)) in_ready <= 1'b0;
        else                                in_addr  <= in_addr + InAw'(1);
      end
      if (out_we) out_cnt <= out_cnt + OutCntW'(1);

      unique case (state)
        StIdle: begin
          if (start) begin
            nb          <= num_batches;
            batch_cnt   <= '0;
            out_cnt     <= '0;
            err_timeout <= 1'b0;
            err_ovf     <= 1'b0;
            busy        <= 1'b1;
            if (num_batches == '0) begin
              state <= StFinish;
              done  <= 1'b1;
            end else begin
              state      <= StStart;
              core_start <= 1'b1;
              core_oe    <= 1'b1;
            end
          end else if (load_en) begin
            state    <= StLoad;
            in_addr  <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        StLoad: begin
          if (!load_en) begin
            state    <= StIdle;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end
        end
        StStart: begin
          state  <= StWaitAck;
          to_cnt <= '0;
        end
        StWaitAck: begin
          if (to_expired) begin
            state       <= StFinish;
            err_timeout <= 1'b1;
            core_oe     <= 1'b0;
          end else begin
            to_cnt <= to_cnt + ToW'(1);
            if (!core_done) state <= StWaitDone;
          end
        end
        StWaitDone: begin
          // A result arriving on the final waiting cycle still counts.
          if (core_done) begin
            state <= StCapture;
          end else if (to_expired) begin
            state       <= StFinish;
            err_timeout <= 1'b1;
            core_oe     <= 1'b0;
          end else begin
            to_cnt <= to_cnt + ToW'(1);
          end
        end
        StCapture: begin
          if (ovf_now) begin
            state   <= StFinish;
            err_ovf <= 1'b1;
            core_oe <= 1'b0;
          end else begin
            state <= StWrite;
          end
        end
        StWrite: begin
          if (ser_last) begin
            batch_cnt <= batch_cnt + BATCH_W'(1);
            if ((batch_cnt + BATCH_W'(1)) == nb) begin
              state   <= StFinish;
              core_oe <= 1'b0;
              done    <= !(err_timeout || err_ovf);
            end else begin
              state      <= StStart;
              core_start <= 1'b1;
            end
          end
        end
        StFinish: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
